// File: rtl/rec_ec_fetch.sv
// rec_ec_fetch: walks every rec-memory word address once per LCU, resolves the
// physical bank through the rec translation buffer, issues the bank read and
// streams the returned words to the entropy coder over valid/ready.
module rec_ec_fetch #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned LAST_ADDR  = 383,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8:0]            tlb_addr_o,
   input  logic [1:0]            tlb_bank_i,
   input  logic                  tlb_cbank_i,
   output logic                  mem_ren_o,
   output logic [1:0]            mem_bank_o,
   output logic                  mem_cbank_o,
   output logic [8:0]            mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic                  ec_valid_o,
   input  logic                  ec_ready_i,
   output logic [DATA_WIDTH-1:0] ec_data_o,
   output logic [8:0]            ec_addr_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
   localparam logic [8:0]    LAST_C    = 9'(LAST_ADDR);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [8:0]            r_ptr;
   logic                  r_cbank;
   logic                  r_inflight;
   logic [8:0]            r_inf_addr;
   logic                  r_done;

   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [8:0]            r_fifo_addr [FIFO_DEPTH];
   logic [AW-1:0]         r_wr;
   logic [AW-1:0]         r_rd;
   logic [CW-1:0]         r_count;

   logic                  w_ren;
   logic                  w_done_set;
   logic                  w_start;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;
   logic [CW:0]           w_occ;

   // Issue credit counts words buffered plus the one read in flight; a pop in
   // the same cycle does not free a slot until the next cycle.
   assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & ec_ready_i;
   assign w_push  = r_inflight;
   assign w_start = (r_state == S_IDLE) & start_i;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state, read issue and completion decode.
   always_comb begin
      w_next     = r_state;
      w_ren      = 1'b0;
      w_done_set = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start_i) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_occ < DEPTH_OCC) begin
               w_ren = 1'b1;
               if (r_ptr == LAST_C) w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Finish on the cycle the last buffered word leaves, so done_o
            // lands one cycle after that pop.
            if (!r_inflight &&
                ((r_count == '0) || ((r_count == CW'(1)) && w_pop))) begin
               w_next     = S_IDLE;
               w_done_set = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Pass control: read pointer, latched buffer half, in-flight tracking, FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_cbank    <= 1'b0;
         r_inflight <= 1'b0;
         r_inf_addr <= '0;
         r_done     <= 1'b0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
      end else begin
         r_done     <= w_done_set;
         r_inflight <= w_ren;
         r_inf_addr <= r_ptr;
         if (w_start) begin
            r_ptr   <= '0;
            r_cbank <= tlb_cbank_i;
         end else if (w_ren) begin
            r_ptr <= r_ptr + 9'd1;
         end else if (w_done_set) begin
            r_ptr <= '0;
         end
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are masked at the output while empty, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr] <= mem_data_i;
         r_fifo_addr[r_wr] <= r_inf_addr;
      end
   end

   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = r_done;
   assign tlb_addr_o  = r_ptr;
   assign mem_ren_o   = w_ren;
   assign mem_bank_o  = w_ren ? tlb_bank_i : '0;
   assign mem_cbank_o = r_cbank;
   assign mem_addr_o  = w_ren ? r_ptr : '0;
   assign ec_valid_o  = w_valid;
   assign ec_data_o   = w_valid ? r_fifo_data[r_rd] : '0;
   assign ec_addr_o   = w_valid ? r_fifo_addr[r_rd] : '0;

   // Issue credit guarantees a free slot for every returning word.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_rec_ec_fetch.sv
// tb_rec_ec_fetch: directed passes over rec_ec_fetch with a translation-buffer
// model, a one-cycle-latency bank memory model and per-cycle output checks.
module tb_rec_ec_fetch;

   localparam int DW    = 128;
   localparam int NW    = 384;
   localparam int LIMIT = 3000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          busy_o;
   logic          done_o;
   logic [8:0]    tlb_addr_o;
   logic [1:0]    tlb_bank_i;
   logic          tlb_cbank_i;
   logic          mem_ren_o;
   logic [1:0]    mem_bank_o;
   logic          mem_cbank_o;
   logic [8:0]    mem_addr_o;
   logic [DW-1:0] mem_data_i;
   logic          ec_valid_o;
   logic          ec_ready_i;
   logic [DW-1:0] ec_data_o;
   logic [8:0]    ec_addr_o;

   int  n_chk  = 0;
   int  n_fail = 0;
   logic tlb_mode = 1'b0;

   rec_ec_fetch #(.DATA_WIDTH(DW), .LAST_ADDR(383), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .tlb_addr_o(tlb_addr_o), .tlb_bank_i(tlb_bank_i), .tlb_cbank_i(tlb_cbank_i),
      .mem_ren_o(mem_ren_o), .mem_bank_o(mem_bank_o), .mem_cbank_o(mem_cbank_o),
      .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .ec_valid_o(ec_valid_o),
      .ec_ready_i(ec_ready_i), .ec_data_o(ec_data_o), .ec_addr_o(ec_addr_o)
   );

   always #5 clk = ~clk;

   // Translation buffer: constant bank 2, or addr[3:2] for luma and 3 for chroma.
   assign tlb_bank_i = tlb_mode ? ((tlb_addr_o < 9'd256) ? tlb_addr_o[3:2] : 2'd3) : 2'd2;

   function automatic logic [1:0] exp_bank(input logic [8:0] a);
      if (!tlb_mode)       return 2'd2;
      else if (a < 9'd256) return a[3:2];
      else                 return 2'd3;
   endfunction

   // Word content encodes address, bank and half actually used for the read.
   function automatic logic [DW-1:0] mk_data(input logic [8:0] a, input logic [1:0] b,
                                             input logic cb);
      return {32'hDEAD0000 + 32'(a), 30'd0, b, 31'd0, cb, ~(32'(a))};
   endfunction

   // Bank memory: data valid one cycle after the read strobe, junk otherwise.
   always @(posedge clk) begin
      if (mem_ren_o) mem_data_i <= mk_data(mem_addr_o, mem_bank_o, mem_cbank_o);
      else           mem_data_i <= {4{32'hBADBAD00}};
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},  DW'(busy_o), '0);
      chk({tag, "_done"},  DW'(done_o), '0);
      chk({tag, "_ren"},   DW'(mem_ren_o), '0);
      chk({tag, "_valid"}, DW'(ec_valid_o), '0);
      chk({tag, "_taddr"}, DW'(tlb_addr_o), '0);
      chk({tag, "_maddr"}, DW'(mem_addr_o), '0);
      chk({tag, "_eaddr"}, DW'(ec_addr_o), '0);
      chk({tag, "_bank"},  DW'(mem_bank_o), '0);
      chk({tag, "_cbank"}, DW'(mem_cbank_o), '0);
      chk({tag, "_data"},  ec_data_o, '0);
   endtask

   // rmode: 0 ready high, 1 ready low on cycles lo..hi, 2 random 50 %.
   // exp_done: expected done cycle (0 = not fixed). abort_at: assert rst once
   // this many words have been accepted (0 = never).
   task automatic run_pass(input string tag, input logic cb, input int rmode,
                           input int lo, input int hi, input bit cb_toggle,
                           input bit extra_start, input int exp_done, input int abort_at);
      int iss_cnt  = 0;
      int pop_cnt  = 0;
      int last_iss = 0;
      int last_pop = 0;
      int buffered;
      bit fin = 1'b0;
      int cyc = 1;
      tlb_cbank_i = cb;
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      while (!fin && cyc < LIMIT) begin
         @(negedge clk);
         case (rmode)
            0:       ec_ready_i = 1'b1;
            1:       ec_ready_i = !(cyc >= lo && cyc <= hi);
            default: ec_ready_i = 1'($urandom_range(0, 1));
         endcase
         start_i = extra_start && (cyc == 10 || cyc == 200);
         if (cb_toggle && (cyc == 50 || cyc == 150)) tlb_cbank_i = ~tlb_cbank_i;
         #1;
         if (abort_at > 0 && pop_cnt == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            chk_reset_vals({tag, "_abort"});
            rst = 1'b0;
            fin = 1'b1;
         end else begin
            buffered = iss_cnt - last_iss - pop_cnt;
            chk({tag, "_ren"}, DW'(mem_ren_o),
                DW'((iss_cnt < NW) && (iss_cnt - pop_cnt < 4)));
            chk({tag, "_taddr"}, DW'(tlb_addr_o), done_o ? '0 : DW'(iss_cnt));
            if (mem_ren_o) begin
               chk({tag, "_maddr"}, DW'(mem_addr_o), DW'(iss_cnt));
               chk({tag, "_mbank"}, DW'(mem_bank_o), DW'(exp_bank(9'(iss_cnt))));
               chk({tag, "_mcbank"}, DW'(mem_cbank_o), DW'(cb));
            end
            chk({tag, "_valid"}, DW'(ec_valid_o), DW'(buffered != 0));
            if (ec_valid_o) begin
               chk({tag, "_eaddr"}, DW'(ec_addr_o), DW'(pop_cnt));
               chk({tag, "_edata"}, ec_data_o,
                   mk_data(9'(pop_cnt), exp_bank(9'(pop_cnt)), cb));
            end
            if (done_o) begin
               chk({tag, "_done_words"}, DW'(pop_cnt), DW'(NW));
               chk({tag, "_done_busy"}, DW'(busy_o), '0);
               chk({tag, "_done_lat"}, DW'(cyc - last_pop), DW'(1));
               if (exp_done > 0) chk({tag, "_done_cyc"}, DW'(cyc), DW'(exp_done));
               fin = 1'b1;
            end else begin
               chk({tag, "_busy"}, DW'(busy_o), DW'(1));
            end
            if (ec_valid_o && ec_ready_i) begin
               pop_cnt++;
               last_pop = cyc;
            end
            last_iss = int'(mem_ren_o);
            iss_cnt += int'(mem_ren_o);
         end
         cyc++;
      end
      if (!fin) chk({tag, "_timeout"}, '0, DW'(1));
      start_i    = 1'b0;
      ec_ready_i = 1'b1;
   endtask

   initial begin
      rst         = 1'b1;
      start_i     = 1'b0;
      tlb_cbank_i = 1'b0;
      ec_ready_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("idle");

      tlb_mode = 1'b0;
      run_pass("flat",   1'b0, 0, 0, 0, 1'b0, 1'b0, 387, 0);
      tlb_mode = 1'b1;
      run_pass("tlb",    1'b0, 0, 0, 0, 1'b0, 1'b0, 387, 0);
      run_pass("cbank",  1'b1, 0, 0, 0, 1'b1, 1'b0, 387, 0);
      run_pass("stall",  1'b0, 1, 5, 20, 1'b0, 1'b0, 0, 0);
      run_pass("random", 1'b1, 2, 0, 0, 1'b0, 1'b1, 0, 0);
      run_pass("abort",  1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 100);
      run_pass("after",  1'b0, 0, 0, 0, 1'b0, 1'b0, 387, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
